// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the multicycle sequencer and the datapath/memories.
// The master modport is the sequencer's view; the slave modport is the datapath/memory view.
interface multicycle_sequencer_if #(
  parameter int INSTRUCTION_SIZE = 32,
  parameter int COUNTER_WIDTH    = 64
);
  logic                        enable;
  logic [INSTRUCTION_SIZE-1:0] instruction;
  logic                        imem_ready;
  logic                        dmem_ready;
  logic                        imem_req;
  logic                        ir_load_en;
  logic                        pc_write_en;
  logic                        dmem_req;
  logic                        cu_dm_write_en;
  logic                        cu_rf_write_en;
  logic                        cu_mux_0_sel;
  logic                        cu_mux_1_sel;
  logic                        cu_mux_2_sel;
  logic [2:0]                  cu_alu_operation;
  logic [2:0]                  state;
  logic [1:0]                  fault_cause;
  logic [COUNTER_WIDTH-1:0]    instret;

  modport master (
    input  enable, instruction, imem_ready, dmem_ready,
    output imem_req, ir_load_en, pc_write_en, dmem_req, cu_dm_write_en,
           cu_rf_write_en, cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel,
           cu_alu_operation, state, fault_cause, instret
  );

  modport slave (
    output enable, instruction, imem_ready, dmem_ready,
    input  imem_req, ir_load_en, pc_write_en, dmem_req, cu_dm_write_en,
           cu_rf_write_en, cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel,
           cu_alu_operation, state, fault_cause, instret
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM: FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK],
// with memory-ready timeouts, sticky illegal/timeout faults and a retired-instruction counter.
module multicycle_sequencer #(
  parameter int INSTRUCTION_SIZE = 32,
  parameter int COUNTER_WIDTH    = 64,
  parameter int MEM_TIMEOUT      = 255
) (
  input logic                    clk,
  input logic                    rst,
  multicycle_sequencer_if.master bus
);
  localparam int WAIT_WIDTH = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT = WAIT_WIDTH'(MEM_TIMEOUT);
  localparam bit TIMEOUT_ON = (MEM_TIMEOUT > 0);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  state_t                   r_state,   w_stateNext;
  logic [WAIT_WIDTH-1:0]    r_wait,    w_waitNext;
  logic [1:0]               r_cause,   w_causeNext;
  logic [COUNTER_WIDTH-1:0] r_instret, w_instretNext;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_isLoad, w_isStore, w_isR, w_isSub, w_isI, w_legal, w_timeout;
  logic       w_unused;

  assign w_opcode  = bus.instruction[6:0];
  assign w_funct3  = bus.instruction[14:12];
  assign w_funct7  = bus.instruction[31:25];
  assign w_unused  = ^{bus.instruction[24:15], bus.instruction[11:7]};
  assign w_isLoad  = (w_opcode == 7'b0000011);
  assign w_isStore = (w_opcode == 7'b0100011);
  assign w_isR     = (w_opcode == 7'b0110011) && (w_funct3 == 3'b000) &&
                     ((w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000));
  assign w_isSub   = w_isR && (w_funct7 == 7'b0100000);
  assign w_isI     = (w_opcode == 7'b0010011) && (w_funct3 == 3'b000);
  assign w_legal   = w_isLoad || w_isStore || w_isR || w_isI;
  assign w_timeout = TIMEOUT_ON && (r_wait == WAIT_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_wait    <= '0;
      r_cause   <= 2'b00;
      r_instret <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_wait    <= w_waitNext;
      r_cause   <= w_causeNext;
      r_instret <= w_instretNext;
    end
  end

  // A ready seen in the same cycle as the wait limit takes priority over the timeout.
  always_comb begin
    w_stateNext   = r_state;
    w_waitNext    = r_wait;
    w_causeNext   = r_cause;
    w_instretNext = r_instret;
    case (r_state)
      ST_FETCH: begin
        if (bus.imem_ready) begin
          w_waitNext = '0;
          if (bus.enable) w_stateNext = ST_DECODE;
        end else if (bus.enable) begin
          if (w_timeout) begin
            w_stateNext = ST_FAULT;
            w_causeNext = 2'b10;
          end else begin
            w_waitNext = r_wait + WAIT_WIDTH'(1);
          end
        end
      end
      ST_DECODE: begin
        if (w_legal) begin
          w_stateNext = ST_EXECUTE;
        end else begin
          w_stateNext = ST_FAULT;
          w_causeNext = 2'b01;
        end
      end
      ST_EXECUTE: begin
        w_waitNext  = '0;
        w_stateNext = (w_isLoad || w_isStore) ? ST_MEMORY : ST_WRITEBACK;
      end
      ST_MEMORY: begin
        if (bus.dmem_ready) begin
          w_waitNext = '0;
          if (w_isStore) begin
            w_stateNext   = ST_FETCH;
            w_instretNext = r_instret + COUNTER_WIDTH'(1);
          end else begin
            w_stateNext = ST_WRITEBACK;
          end
        end else if (w_timeout) begin
          w_stateNext = ST_FAULT;
          w_causeNext = 2'b11;
        end else begin
          w_waitNext = r_wait + WAIT_WIDTH'(1);
        end
      end
      ST_WRITEBACK: begin
        w_waitNext    = '0;
        w_stateNext   = ST_FETCH;
        w_instretNext = r_instret + COUNTER_WIDTH'(1);
      end
      ST_FAULT: w_stateNext = ST_FAULT;
      default:  w_stateNext = ST_FAULT;
    endcase
  end

  // Reset gates every output combinationally so requests drop the moment rst rises.
  always_comb begin
    bus.imem_req         = 1'b0;
    bus.ir_load_en       = 1'b0;
    bus.pc_write_en      = 1'b0;
    bus.dmem_req         = 1'b0;
    bus.cu_dm_write_en   = 1'b0;
    bus.cu_rf_write_en   = 1'b0;
    bus.cu_mux_0_sel     = 1'b0;
    bus.cu_mux_1_sel     = 1'b0;
    bus.cu_mux_2_sel     = 1'b0;
    bus.cu_alu_operation = 3'b000;
    if (!rst) begin
      case (r_state)
        ST_FETCH: begin
          bus.imem_req    = bus.enable;
          bus.ir_load_en  = bus.enable && bus.imem_ready;
          bus.pc_write_en = bus.enable && bus.imem_ready;
        end
        ST_EXECUTE: begin
          bus.cu_mux_1_sel     = w_isR;
          bus.cu_alu_operation = w_isSub ? 3'b001 : 3'b000;
        end
        ST_MEMORY: begin
          bus.dmem_req         = 1'b1;
          bus.cu_dm_write_en   = w_isStore;
          bus.cu_mux_1_sel     = w_isR;
          bus.cu_alu_operation = w_isSub ? 3'b001 : 3'b000;
        end
        ST_WRITEBACK: begin
          bus.cu_rf_write_en   = 1'b1;
          bus.cu_mux_2_sel     = w_isLoad;
          bus.cu_mux_1_sel     = w_isR;
          bus.cu_alu_operation = w_isSub ? 3'b001 : 3'b000;
        end
        default: ;
      endcase
    end
  end

  assign bus.state       = rst ? 3'd0  : r_state;
  assign bus.fault_cause = rst ? 2'b00 : r_cause;
  assign bus.instret     = rst ? '0    : r_instret;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed instructions plus randomized
// instruction/ready-delay sequences compared cycle by cycle against an expected control trace.
module tb_multicycle_sequencer;
  localparam int TMO = 4;
  localparam int CW  = 4;
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2,
                         MEM = 3'd3, WB = 3'd4, FLT = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   modelInstret = 0;

  always #5 clk = ~clk;

  multicycle_sequencer_if #(.INSTRUCTION_SIZE(32), .COUNTER_WIDTH(CW)) io ();

  multicycle_sequencer #(
    .INSTRUCTION_SIZE(32), .COUNTER_WIDTH(CW), .MEM_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(io)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic coin();
    return 1'($urandom_range(0, 1));
  endfunction

  // Packed control word: state, cause, imem_req, ir_load, pc_we, dmem_req, dm_we, rf_we, mux0..2, alu
  function automatic logic [16:0] expVec(input logic [2:0] st, input logic [1:0] cs,
                                         input logic ireq, input logic ild, input logic dreq,
                                         input logic dwe, input logic rwe, input logic m1,
                                         input logic m2, input logic [2:0] alu);
    return {st, cs, ireq, ild, ild, dreq, dwe, rwe, 1'b0, m1, m2, alu};
  endfunction

  function automatic logic [16:0] obsVec();
    return {io.state, io.fault_cause, io.imem_req, io.ir_load_en, io.pc_write_en,
            io.dmem_req, io.cu_dm_write_en, io.cu_rf_write_en, io.cu_mux_0_sel,
            io.cu_mux_1_sel, io.cu_mux_2_sel, io.cu_alu_operation};
  endfunction

  // 0 illegal, 1 load, 2 store, 3 add, 4 sub, 5 addi
  function automatic int classify(input logic [31:0] ins);
    if (ins[6:0] == 7'b0000011) return 1;
    if (ins[6:0] == 7'b0100011) return 2;
    if (ins[6:0] == 7'b0110011 && ins[14:12] == 3'b000) begin
      if (ins[31:25] == 7'b0000000) return 3;
      if (ins[31:25] == 7'b0100000) return 4;
      return 0;
    end
    if (ins[6:0] == 7'b0010011 && ins[14:12] == 3'b000) return 5;
    return 0;
  endfunction

  function automatic logic [31:0] genInstr(input int sel);
    logic [31:0] r;
    r = $urandom;
    case (sel)
      0: begin r[6:0] = 7'b0110011; r[14:12] = 3'b000; r[31:25] = 7'b0000000; end
      1: begin r[6:0] = 7'b0110011; r[14:12] = 3'b000; r[31:25] = 7'b0100000; end
      2: begin r[6:0] = 7'b0010011; r[14:12] = 3'b000; end
      3: r[6:0] = 7'b0000011;
      4: r[6:0] = 7'b0100011;
      5: begin r[6:0] = 7'b0110011; r[14:12] = 3'($urandom_range(1, 7)); end
      6: begin r[6:0] = 7'b0110011; r[14:12] = 3'b000; r[31:25] = coin() ? 7'h01 : 7'h21; end
      7: begin r[6:0] = 7'b0010011; r[14:12] = 3'($urandom_range(1, 7)); end
      default: ;
    endcase
    return r;
  endfunction

  task automatic stepCycle(input logic [16:0] exp, input logic en, input logic imr,
                           input logic dmr, input string tag);
    io.enable     = en;
    io.imem_ready = imr;
    io.dmem_ready = dmr;
    @(negedge clk);
    checkOutput(tag, 64'(obsVec()), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input string tag);
    rst           = 1'b1;
    io.enable     = 1'b1;
    io.imem_ready = 1'b1;
    io.dmem_ready = 1'b1;
    #1;
    checkOutput({tag, "Out"}, 64'(obsVec()), 64'd0);
    checkOutput({tag, "Instret"}, 64'(io.instret), 64'd0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    modelInstret = 0;
  endtask

  // Drives one instruction with the given ready delays and checks the expected per-cycle trace.
  task automatic applyStimulus(input logic [31:0] instr, input int dI, input int dD,
                               input int idle, input int abortAt, input int faultHold,
                               input string tag);
    int         cls;
    logic       m1, m2, isStore;
    logic [2:0] alu;
    logic [1:0] cause;
    bit         faulted;
    cls     = classify(instr);
    m1      = (cls == 3) || (cls == 4);
    m2      = (cls == 1);
    isStore = (cls == 2);
    alu     = (cls == 4) ? 3'b001 : 3'b000;
    cause   = 2'b00;
    faulted = 1'b0;
    io.instruction = instr;
    for (int i = 0; i < idle; i++)
      stepCycle(expVec(FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, coin(), coin(), {tag, "Idle"});
    for (int k = 0; k <= dI; k++) begin
      if (k == dI) begin
        stepCycle(expVec(FETCH, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1, coin(), {tag, "Fetch"});
      end else begin
        stepCycle(expVec(FETCH, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, coin(), {tag, "FetchWait"});
        if (k == TMO) begin faulted = 1'b1; cause = 2'b10; break; end
      end
    end
    if (!faulted) begin
      stepCycle(expVec(DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0), coin(), coin(), coin(), {tag, "Decode"});
      if (cls == 0) begin faulted = 1'b1; cause = 2'b01; end
    end
    if (!faulted) begin
      stepCycle(expVec(EXEC, 0, 0, 0, 0, 0, 0, m1, 0, alu), coin(), coin(), coin(), {tag, "Exec"});
      if (cls == 1 || cls == 2) begin
        for (int k = 0; k <= dD; k++) begin
          if (k == abortAt) begin
            doReset({tag, "Abort"});
            return;
          end
          if (k == dD) begin
            stepCycle(expVec(MEM, 0, 0, 0, 1, isStore, 0, m1, 0, alu), coin(), coin(), 1'b1, {tag, "Mem"});
          end else begin
            stepCycle(expVec(MEM, 0, 0, 0, 1, isStore, 0, m1, 0, alu), coin(), coin(), 1'b0, {tag, "MemWait"});
            if (k == TMO) begin faulted = 1'b1; cause = 2'b11; break; end
          end
        end
      end
      if (!faulted && !isStore)
        stepCycle(expVec(WB, 0, 0, 0, 0, 0, 1, m1, m2, alu), coin(), coin(), coin(), {tag, "Wb"});
      if (!faulted) begin
        modelInstret = (modelInstret + 1) % (1 << CW);
        checkOutput({tag, "Instret"}, 64'(io.instret), 64'(modelInstret));
      end
    end
    if (faulted) begin
      for (int i = 0; i < faultHold; i++)
        stepCycle(expVec(FLT, cause, 0, 0, 0, 0, 0, 0, 0, 0), coin(), coin(), coin(), {tag, "Fault"});
      checkOutput({tag, "FaultInstret"}, 64'(io.instret), 64'(modelInstret));
      doReset({tag, "Rst"});
    end
  endtask

  initial begin
    int sel, r, dI, dD;
    io.instruction = 32'h0;
    io.enable      = 1'b0;
    io.imem_ready  = 1'b0;
    io.dmem_ready  = 1'b0;
    $display("[TB] starting multicycle_sequencer bench");
    doReset("init");

    applyStimulus(32'h002081B3, 0, 0, 0, -1, 3, "add");
    applyStimulus(32'h402081B3, 0, 0, 0, -1, 3, "sub");
    applyStimulus(32'h0080A283, 0, 3, 0, -1, 3, "lw");
    applyStimulus(32'h0050A423, 0, 0, 0, -1, 3, "sw");
    applyStimulus(32'h00108093, 1, 0, 0, -1, 3, "addi");
    applyStimulus(32'h002081B3, 0, 0, 40, -1, 3, "enLow");
    applyStimulus(32'h002081B3, TMO, 0, 0, -1, 3, "imemAtLimit");
    applyStimulus(32'h0080A283, 0, TMO, 0, -1, 3, "dmemAtLimit");
    applyStimulus(32'h0000006F, 0, 0, 0, -1, 20, "illegal");
    applyStimulus(32'h002081B3, TMO + 1, 0, 0, -1, 3, "imemTimeout");
    applyStimulus(32'h0050A423, 0, TMO + 1, 0, -1, 3, "dmemTimeout");
    applyStimulus(32'h0080A283, 0, 3, 0, 1, 3, "abort");

    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 9);
      r   = $urandom_range(0, 9);
      dI  = (r < 6) ? $urandom_range(0, 1) : ((r < 9) ? $urandom_range(2, TMO) : TMO + 1);
      r   = $urandom_range(0, 9);
      dD  = (r < 6) ? $urandom_range(0, 1) : ((r < 9) ? $urandom_range(2, TMO) : TMO + 1);
      applyStimulus(genInstr(sel), dI, dD, $urandom_range(0, 2), -1, 3, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
